// File: rtl/vga_timing_gen_if.sv
// Renderer-facing and pin-facing signal bundle for vga_timing_gen.
// The timing generator owns the master side; renderer/connector logic uses the slave side.
interface vga_timing_gen_if;
    logic [2:0] red_in;
    logic [2:0] green_in;
    logic [1:0] blue_in;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       pix_en;
    logic       active;
    logic       frame_tick;
    logic       hsync;
    logic       vsync;
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;

    modport master (
        input  red_in, green_in, blue_in,
        output hc, vc, pix_en, active, frame_tick,
        output hsync, vsync, red, green, blue
    );

    modport slave (
        output red_in, green_in, blue_in,
        input  hc, vc, pix_en, active, frame_tick,
        input  hsync, vsync, red, green, blue
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing: pixel divider, hc/vc counters, frame tick, registered sync/RGB pins.
// Define VGA_TEST_PATTERN_EN to replace renderer RGB with eight 80-px vertical colour bars.
module vga_timing_gen #(
    parameter int CLK_DIV = 4,
    parameter int HPIXELS = 800,
    parameter int VLINES  = 521,
    parameter int HPULSE  = 96,
    parameter int VPULSE  = 2,
    parameter int HBP     = 144,
    parameter int HFP     = 784,
    parameter int VBP     = 31,
    parameter int VFP     = 511
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master vga
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST  = 10'(HPIXELS - 1);
    localparam logic [9:0] V_LAST  = 10'(VLINES - 1);
    localparam logic [9:0] H_PULSE = 10'(HPULSE);
    localparam logic [9:0] V_PULSE = 10'(VPULSE);
    localparam logic [9:0] H_BP    = 10'(HBP);
    localparam logic [9:0] H_FP    = 10'(HFP);
    localparam logic [9:0] V_BP    = 10'(VBP);
    localparam logic [9:0] V_FP    = 10'(VFP);

    logic [DIV_W-1:0] div;
    logic [9:0]       hc_q;
    logic [9:0]       vc_q;
    logic             pix_en_q;
    logic             tick_q;
    logic             hsync_q;
    logic             vsync_q;
    logic [2:0]       red_q;
    logic [2:0]       green_q;
    logic [1:0]       blue_q;
    logic             in_window;
    logic [2:0]       red_d;
    logic [2:0]       green_d;
    logic [1:0]       blue_d;

    assign in_window = (hc_q >= H_BP) && (hc_q < H_FP) &&
                       (vc_q >= V_BP) && (vc_q < V_FP);

`ifdef VGA_TEST_PATTERN_EN
    logic [9:0] x_off;
    logic [9:0] bar;

    assign x_off = hc_q - H_BP;
    assign bar   = x_off / 10'd80;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (in_window) begin
            red_d   = {3{bar[2]}};
            green_d = {3{bar[1]}};
            blue_d  = {2{bar[0]}};
        end
    end
`else
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (in_window) begin
            red_d   = vga.red_in;
            green_d = vga.green_in;
            blue_d  = vga.blue_in;
        end
    end
`endif

    // pix_en rises the clk after div reaches its last value, so the first strobe
    // appears CLK_DIV clks after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            div      <= '0;
            pix_en_q <= 1'b0;
        end else begin
            pix_en_q <= (div == DIV_LAST);
            div      <= (div == DIV_LAST) ? '0 : div + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc_q   <= '0;
            vc_q   <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= pix_en_q && (hc_q == H_LAST) && (vc_q == V_LAST);
            if (pix_en_q) begin
                if (hc_q == H_LAST) begin
                    hc_q <= '0;
                    vc_q <= (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
                end else begin
                    hc_q <= hc_q + 10'd1;
                end
            end
        end
    end

    // Pin stage samples the current pixel, so sync and RGB both lag hc/vc by one pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else if (pix_en_q) begin
            hsync_q <= !(hc_q < H_PULSE);
            vsync_q <= !(vc_q < V_PULSE);
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign vga.hc         = hc_q;
    assign vga.vc         = vc_q;
    assign vga.pix_en     = pix_en_q;
    assign vga.active     = in_window;
    assign vga.frame_tick = tick_q;
    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.red        = red_q;
    assign vga.green      = green_q;
    assign vga.blue       = blue_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for reset, line wrap, hsync and async reset;
// a shrunken-geometry instance for frame timing and blanking boundaries.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    vga_timing_gen_if ifa ();
    vga_timing_gen_if ifb ();

    vga_timing_gen u_a (
        .clk (clk),
        .rst (rst_a),
        .vga (ifa)
    );

    // Small frame: 40 px x 12 lines, active hc 8..31, vc 3..9, 2 clks per pixel.
    vga_timing_gen #(
        .CLK_DIV (2),
        .HPIXELS (40),
        .VLINES  (12),
        .HPULSE  (4),
        .VPULSE  (2),
        .HBP     (8),
        .HFP     (32),
        .VBP     (3),
        .VFP     (10)
    ) u_b (
        .clk (clk),
        .rst (rst_b),
        .vga (ifb)
    );

`ifdef VGA_TEST_PATTERN_EN
    // Active window of the small instance lies entirely in bar 0.
    localparam int IN_R = 0;
    localparam int IN_G = 0;
    localparam int IN_B = 0;
`else
    localparam int IN_R = 7;
    localparam int IN_G = 5;
    localparam int IN_B = 3;
`endif

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_a(input int h, input int v);
        int n = 0;
        while (!(ifa.hc == 10'(h) && ifa.vc == 10'(v) && ifa.pix_en) && n < 30000) begin
            step();
            n++;
        end
        check($sformatf("wait_a_%0d_%0d", h, v), 32'(n < 30000), 1);
    endtask

    task automatic wait_b(input int h, input int v);
        int n = 0;
        while (!(ifb.hc == 10'(h) && ifb.vc == 10'(v) && ifb.pix_en) && n < 1200) begin
            step();
            n++;
        end
        check($sformatf("wait_b_%0d_%0d", h, v), 32'(n < 1200), 1);
    endtask

    task automatic check_b_pixel(input int h, input int v, input int act,
                                 input int er, input int eg, input int eb);
        wait_b(h, v);
        check($sformatf("active_%0d_%0d", h, v), 32'(ifb.active), act);
        step();
        check($sformatf("red_%0d_%0d", h, v),   32'(ifb.red),   er);
        check($sformatf("green_%0d_%0d", h, v), 32'(ifb.green), eg);
        check($sformatf("blue_%0d_%0d", h, v),  32'(ifb.blue),  eb);
    endtask

    initial begin
        int lows;
        int falls;
        int first_low_hc;
        logic prev_hs;
        int ticks;
        int first_tick;
        int second_tick;
        int vlow;

        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.red_in = 3'd7; ifa.green_in = 3'd5; ifa.blue_in = 2'd3;
        ifb.red_in = 3'd7; ifb.green_in = 3'd5; ifb.blue_in = 2'd3;

        // Reset values while rst is held.
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rst_hc",     32'(ifa.hc), 0);
        check("rst_vc",     32'(ifa.vc), 0);
        check("rst_pix_en", 32'(ifa.pix_en), 0);
        check("rst_tick",   32'(ifa.frame_tick), 0);
        check("rst_active", 32'(ifa.active), 0);
        check("rst_hsync",  32'(ifa.hsync), 1);
        check("rst_vsync",  32'(ifa.vsync), 1);
        check("rst_rgb",    32'({ifa.red, ifa.green, ifa.blue}), 0);

        // Strobe cadence: pix_en on clks 4, 8, 12; hc=1 after first strobe edge.
        rst_a = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("pix_en_clk%0d", k), 32'(ifa.pix_en), 32'(k % 4 == 0));
            if (k <= 4) check($sformatf("hc_hold_clk%0d", k), 32'(ifa.hc), 0);
            if (k == 5) check("hc_first_adv", 32'(ifa.hc), 1);
        end
        check("hc_clk12", 32'(ifa.hc), 2);

        // Line wrap at (799,5).
        wait_a(799, 5);
        step();
        check("wrap_hc", 32'(ifa.hc), 0);
        check("wrap_vc", 32'(ifa.vc), 6);
        check("wrap_hsync_pre", 32'(ifa.hsync), 1);

        // One full line of hsync: a single 384-clk low run starting at hc=1.
        lows = 0; falls = 0; first_low_hc = -1; prev_hs = ifa.hsync;
        for (int k = 0; k < 3200; k++) begin
            step();
            if (!ifa.hsync) begin
                if (first_low_hc < 0) first_low_hc = int'(ifa.hc);
                lows++;
            end
            if (prev_hs && !ifa.hsync) falls++;
            prev_hs = ifa.hsync;
        end
        check("hsync_low_clks", 32'(lows), 384);
        check("hsync_falls", 32'(falls), 1);
        check("hsync_first_hc", 32'(first_low_hc), 1);

        // Async reset between edges mid-line.
        wait_a(400, 7);
        #2 rst_a = 1'b1;
        #1;
        check("arst_hc",     32'(ifa.hc), 0);
        check("arst_vc",     32'(ifa.vc), 0);
        check("arst_pix_en", 32'(ifa.pix_en), 0);
        check("arst_hsync",  32'(ifa.hsync), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        ticks = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (ifa.frame_tick) ticks++;
        end
        check("arst_no_tick", 32'(ticks), 0);
        check("arst_hc_40",   32'(ifa.hc), 9);
        check("arst_vc_40",   32'(ifa.vc), 0);

        // Small instance: frame ticks every 480 px (960 clks), vsync low 80 px.
        rst_b = 1'b0;
        ticks = 0; first_tick = -1; second_tick = -1; vlow = 0;
        for (int k = 1; k <= 2000; k++) begin
            step();
            if (ifb.frame_tick) begin
                ticks++;
                if (ticks == 1) first_tick = k;
                if (ticks == 2) second_tick = k;
                check($sformatf("tick%0d_at_origin", ticks), 32'({ifb.hc, ifb.vc}), 0);
            end
            if (ticks == 1 && !ifb.vsync) vlow++;
        end
        check("tick_count", 32'(ticks), 2);
        check("tick_first", 32'(first_tick), 961);
        check("tick_period", 32'(second_tick - first_tick), 960);
        check("vsync_low_clks", 32'(vlow), 160);

        // Blanking boundaries with red/green/blue_in = 7/5/3.
        check_b_pixel(8, 3, 1, IN_R, IN_G, IN_B);
        ifb.red_in = 3'd1;
        step();
        check("rgb_hold_between_strobes", 32'(ifb.red), IN_R);
        ifb.red_in = 3'd7;
        check_b_pixel(32, 3, 0, 0, 0, 0);
        check("hsync_b_32", 32'(ifb.hsync), 1);
        check_b_pixel(2, 5, 0, 0, 0, 0);
        check("hsync_b_2", 32'(ifb.hsync), 0);
        check_b_pixel(31, 9, 1, IN_R, IN_G, IN_B);
        check_b_pixel(20, 10, 0, 0, 0, 0);
        check_b_pixel(7, 3, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
